regs_arbiter: RTL and testbench
===============================

// Module: regs_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing the single register-file access port among N_REQ requesters.
//  Serialises read/write commands and issues one rf_read_en/rf_write_en pulse per transaction.
//  Waits for rf_data_ready/rf_write_done and returns a per-requester response.
//  Flags an error on timeout (write to a read-only register) and on an out-of-range address.
// PARAMETERS
//  N_REQ       4   number of requesters (>=2)
//  DATA_WIDTH  8   register data width
//  DATA_DEPTH  16  number of registers; ADDR_WIDTH = $clog2(DATA_DEPTH) (localparam)
//  TIMEOUT     4   WAIT cycles before a missing completion is flagged as an error (>=2)
// PORTS
//  clk           in   1                  clock
//  rst_n         in   1                  asynchronous active-low reset
//  req           in   N_REQ              per-requester request level
//  req_we        in   N_REQ              1=write, 0=read, per requester
//  req_addr      in   N_REQ*ADDR_WIDTH   flattened addresses, requester i at [i*AW +: AW]
//  req_wdata     in   N_REQ*DATA_WIDTH   flattened write data
//  gnt           out  N_REQ              one-hot; owner of the transaction in flight
//  rsp_valid     out  N_REQ              one-hot, single-cycle completion
//  rsp_err       out  1                  qualifies rsp_valid: timeout or bad address
//  rsp_rdata     out  DATA_WIDTH         read data, valid with rsp_valid for a read without error
//  busy          out  1                  FSM not in IDLE
//  rf_addr       out  ADDR_WIDTH         register-file address
//  rf_write_en   out  1                  single-cycle write strobe
//  rf_read_en    out  1                  single-cycle read strobe
//  rf_write_data out  DATA_WIDTH         register-file write data
//  rf_read_data  in   DATA_WIDTH         register-file read data
//  rf_data_ready in   1                  read completion (one cycle after rf_read_en)
//  rf_write_done in   1                  write completion; never asserts for read-only registers
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; wait counter 0; round-robin pointer gives requester 0 top priority.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE:
//   - Any req bit set: choose the first set bit at or after ptr (wrapping); latch its we/addr/wdata and index.
//   - Addr >= DATA_DEPTH: go to RESP with err=1 and drive no rf strobe.
//   - Otherwise go to ISSUE.
//  ISSUE: assert rf_read_en or rf_write_en for exactly one cycle with latched addr/data; clear counter; go to WAIT.
//  WAIT (counter increments each cycle):
//   - Read and rf_data_ready: capture rf_read_data; go to RESP, err=0.
//   - Write and rf_write_done: go to RESP, err=0.
//   - Counter reaches TIMEOUT-1 with no completion: go to RESP, err=1.
//   - Completion of the wrong type (e.g. data_ready during a write) is ignored.
//  RESP:
//   - rsp_valid[idx]=1 for one cycle; rsp_err and rsp_rdata are held stable through that cycle.
//   - ptr <= idx+1 mod N_REQ; go to IDLE.
//   - rsp_rdata holds its last value otherwise and is 0 after an error.
//  gnt[idx] is high from ISSUE through RESP inclusive, and 0 in IDLE.
//  rf_addr and rf_write_data hold latched values from ISSUE until the next ISSUE.
//  Latency (no contention): req high at edge k -> rf strobe in cycle k+1 -> rsp_valid in cycle k+3.
//  Handshake:
//   - req is level-sensitive and sampled only in IDLE; hold req/we/addr/wdata stable until rsp_valid.
//   - Drop req on the edge that sees rsp_valid, otherwise a new transaction starts.
//   - req deasserted before selection is simply not served; a change after selection does not affect the latched command.
//  Simultaneous requests: exactly one is granted per IDLE cycle. A continuously requesting set is served cyclically, so no starvation.
//  Back-to-back throughput: one transaction per 4 cycles (IDLE, ISSUE, WAIT, RESP).
//  Reset mid-operation: abort immediately, emit no response, clear all strobes, ptr=0.
// TESTING
//  1. Single read: req[1]=1, we=0, addr=3, file reg3=0xA5 -> rf_read_en pulses 1 cycle;
//     rsp_valid=4'b0010 3 cycles later, rsp_rdata=0xA5, err=0.
//  2. Write: req[2], addr=5, wdata=0x3C, writable -> rf_write_en 1 cycle with addr 5 / data 0x3C; rsp_valid[2], err=0.
//  3. Read-only write: mode mask bit 7 set, req[0] writes addr 7 -> no write_done;
//     rsp_valid[0] with err=1 after TIMEOUT WAIT cycles.
//  4. Contention: req=4'b1111 held, each dropped on its own rsp_valid -> grant order 0,1,2,3; responses 4 cycles apart.
//  5. Fairness: req[0] and req[3] re-asserted continuously -> grants alternate 0,3,0,3; neither is starved.
//  6. Reset in WAIT: pull rst_n low during a read -> no rsp_valid, all outputs 0;
//     the next request is served by requester 0 first.

Source files
------------

// File: rtl/regs_arbiter.sv
// Round-robin sequencer sharing one register-file port among N_REQ requesters.
// One command in flight; completion, timeout or bad address yields a response.
module regs_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int TIMEOUT    = 4,
  localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_we,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic                        rsp_err,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        busy,
  output logic [ADDR_WIDTH-1:0]       rf_addr,
  output logic                        rf_write_en,
  output logic                        rf_read_en,
  output logic [DATA_WIDTH-1:0]       rf_write_data,
  input  logic [DATA_WIDTH-1:0]       rf_read_data,
  input  logic                        rf_data_ready,
  input  logic                        rf_write_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [ADDR_WIDTH:0] DEPTH_L =
    (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         r_idx;
  logic                  r_we;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [CW-1:0]         r_cnt;

  logic                  w_any;
  logic [IW-1:0]         w_sel;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_bad;
  logic                  w_cpl;
  logic                  w_tmo;

  // Scan downward so the lowest offset from r_ptr wins.
  always_comb begin
    int j;
    j     = 0;
    w_any = 1'b0;
    w_sel = '0;
    for (int off = N_REQ-1; off >= 0; off--) begin
      j = int'(r_ptr) + off;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        w_any = 1'b1;
        w_sel = IW'(j);
      end
    end
  end

  assign w_sel_we    = req_we[w_sel];
  assign w_sel_addr  = req_addr[w_sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = req_wdata[w_sel*DATA_WIDTH +: DATA_WIDTH];
  assign w_bad       = {1'b0, w_sel_addr} >= DEPTH_L;
  assign w_cpl       = r_we ? rf_write_done : rf_data_ready;
  assign w_tmo       = r_cnt == CNT_LAST;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = w_bad ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_cpl || w_tmo) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_any) begin
          r_idx <= w_sel;
          r_we  <= w_sel_we;
          r_err <= w_bad;
          // A bad address never reaches the file, so rf_addr keeps its value.
          if (w_bad) begin
            r_rdata <= '0;
          end else begin
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_cpl) begin
            r_err <= 1'b0;
            if (!r_we) r_rdata <= rf_read_data;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        S_RESP: r_ptr <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_idx == IW'(i)) begin
        gnt[i]       = r_state != S_IDLE;
        rsp_valid[i] = r_state == S_RESP;
      end
    end
  end

  assign busy          = r_state != S_IDLE;
  assign rsp_err       = (r_state == S_RESP) && r_err;
  assign rsp_rdata     = r_rdata;
  assign rf_addr       = r_addr;
  assign rf_write_data = r_wdata;
  assign rf_read_en    = (r_state == S_ISSUE) && !r_we;
  assign rf_write_en   = (r_state == S_ISSUE) && r_we;

endmodule

// File: tb/tb_regs_arbiter.sv
// Bench for regs_arbiter: directed scenarios plus randomized traffic
// against a register-file model and a queue-based reference scoreboard.
module tb_regs_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 12;
  localparam int TMO   = 4;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_we = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] rf_addr;
  logic          rf_write_en;
  logic          rf_read_en;
  logic [DW-1:0] rf_write_data;
  logic [DW-1:0] rf_read_data;
  logic          rf_data_ready;
  logic          rf_write_done;

  regs_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .busy(busy), .rf_addr(rf_addr),
    .rf_write_en(rf_write_en), .rf_read_en(rf_read_en),
    .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
    .rf_data_ready(rf_data_ready), .rf_write_done(rf_write_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       id;
    bit       we;
    bit       err;
    logic [7:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ref_mem[16];
  logic [7:0]  rf_mem[16];
  int          lat_tab[16];
  logic [15:0] ro_mask = 16'h0880;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wcnt[N];
  int          got_ord[$];
  int          got_n[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: outcome follows from address range, file mode and latency.
  function automatic exp_t predict(input int id, input bit we,
                                   input logic [3:0] a,
                                   input logic [7:0] d, input int lat);
    exp_t e;
    bit   bad;
    bad     = int'(a) >= DEPTH;
    e.id    = id;
    e.we    = we;
    e.err   = bad || (lat > TMO) || (we && ro_mask[a]);
    if (!e.err && we) ref_mem[a] = d;
    e.rdata = e.err ? 8'h00 : ref_mem[a];
    return e;
  endfunction

  task automatic drive(input int id, input bit we, input logic [3:0] a,
                       input logic [7:0] d, input int lat);
    lat_tab[a] = lat;
    req_we[id] = we;
    req_addr[id*AW +: AW] = a;
    req_wdata[id*DW +: DW] = d;
    sbq.push_back(predict(id, we, a, d, lat));
    req[id] = 1'b1;
  endtask

  // Register-file model: completes lat cycles after the strobe.
  initial begin
    int p_cnt;
    int p_lat;
    bit p_we;
    logic [3:0] p_a;
    logic [7:0] p_d;
    p_cnt = 0; p_lat = 0; p_we = 0; p_a = '0; p_d = '0;
    rf_data_ready = 1'b0;
    rf_write_done = 1'b0;
    rf_read_data  = '0;
    forever begin
      @(posedge clk); #1;
      rf_data_ready = 1'b0;
      rf_write_done = 1'b0;
      rf_read_data  = 8'($urandom);
      if (!rst_n) begin
        p_cnt = 0;
      end else begin
        if (p_cnt > 0) begin
          p_cnt--;
          if (p_cnt == 0 && p_lat <= TMO) begin
            if (!p_we) begin
              rf_data_ready = 1'b1;
              rf_read_data  = rf_mem[p_a];
            end else if (!ro_mask[p_a]) begin
              rf_write_done = 1'b1;
              rf_mem[p_a]   = p_d;
            end else begin
              rf_data_ready = 1'b1;
              rf_read_data  = 8'hEE;
            end
          end
        end
        if (rf_read_en || rf_write_en) begin
          p_we  = rf_write_en;
          p_a   = rf_addr;
          p_d   = rf_write_data;
          p_lat = lat_tab[rf_addr];
          p_cnt = p_lat;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (rst_n) begin
      chk("gnt_vs_busy", $countones(gnt), busy ? 1 : 0);
      if (rsp_valid != '0) begin
        chk("rsp_onehot", $countones(rsp_valid), 1);
        for (int i = 0; i < N; i++) begin
          if (rsp_valid[i]) begin
            k = -1;
            for (int m = 0; m < sbq.size(); m++) begin
              if (sbq[m].id == i) begin
                k = m;
                break;
              end
            end
            if (k < 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL rsp_unexpected: requester %0d at %0t",
                       i, $time);
            end else begin
              e = sbq[k];
              sbq.delete(k);
              chk("rsp_err", rsp_err, e.err);
              if (e.err || !e.we) chk("rsp_rdata", rsp_rdata, e.rdata);
              chk("rsp_gnt", gnt, 1 << i);
            end
            for (int o = 0; o < N; o++) begin
              if (o == i || !req[o]) begin
                wcnt[o] = 0;
              end else begin
                wcnt[o]++;
                chk("starvation", wcnt[o] <= N-1, 1);
              end
            end
          end
        end
      end
    end else begin
      for (int o = 0; o < N; o++) wcnt[o] = 0;
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, gnt, 0);
    chk({nm, "_rsp_valid"}, rsp_valid, 0);
    chk({nm, "_rsp_err"}, rsp_err, 0);
    chk({nm, "_rsp_rdata"}, rsp_rdata, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_rf_addr"}, rf_addr, 0);
    chk({nm, "_rf_wr"}, rf_write_en, 0);
    chk({nm, "_rf_rd"}, rf_read_en, 0);
    chk({nm, "_rf_wdata"}, rf_write_data, 0);
  endtask

  // Single command, checked cycle by cycle from the drive point.
  task automatic txn(input int id, input bit we, input logic [3:0] a,
                     input logic [7:0] d, input int lat, input int exp_n);
    int n;
    int strobes;
    bit seen;
    bit bad;
    n = 0; strobes = 0; seen = 0;
    bad = int'(a) >= DEPTH;
    drive(id, we, a, d, lat);
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      strobes += int'(rf_read_en) + int'(rf_write_en);
      if (n == 1) chk("pre_busy", busy, 0);
      if (n == 2) begin
        chk("gnt_first", gnt, 1 << id);
        if (!bad) begin
          chk("strobe_rd", rf_read_en, !we);
          chk("strobe_wr", rf_write_en, we);
          chk("rf_addr", rf_addr, a);
          if (we) chk("rf_wdata", rf_write_data, d);
        end
      end
      if (rsp_valid != '0) begin
        seen = 1;
        chk("rsp_valid", rsp_valid, 1 << id);
        chk("rsp_cycle", n, exp_n);
      end
    end
    if (!seen) chk("rsp_missing", n, exp_n);
    chk("strobe_count", strobes, bad ? 0 : 1);
    @(posedge clk); #1;
    req[id] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
  endtask

  // Gather responses; each requester drops req after rem responses.
  task automatic collect(input int r0, input int r1,
                         input int r2, input int r3);
    int rem[N];
    int n;
    int left;
    rem = '{r0, r1, r2, r3};
    left = r0 + r1 + r2 + r3;
    n = 0;
    got_ord.delete();
    got_n.delete();
    while (left > 0 && n < 100) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          got_ord.push_back(i);
          got_n.push_back(n);
          rem[i]--;
          left--;
          if (rem[i] == 0) begin
            @(posedge clk); #1;
            req[i] = 1'b0;
          end
        end
      end
    end
    if (left > 0) chk("collect_left", left, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_order(input string nm, input int exp_ord[$]);
    chk({nm, "_count"}, got_ord.size(), exp_ord.size());
    for (int k = 0; k < got_ord.size() && k < exp_ord.size(); k++) begin
      chk({nm, "_order"}, got_ord[k], exp_ord[k]);
      if (k == 0) chk({nm, "_first"}, got_n[k], 4);
      else        chk({nm, "_gap"}, got_n[k] - got_n[k-1], 4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int issued;
    bit act[N];
    int gap[N];
    int age[N];
    logic [N-1:0] v;
    bit any;
    int r;
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'($urandom);
      rf_mem[i]  = ref_mem[i];
      lat_tab[i] = 1;
    end
    for (int o = 0; o < N; o++) wcnt[o] = 0;
    ref_mem[3] = 8'hA5;
    rf_mem[3]  = 8'hA5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(1, 1'b0, 4'd3, 8'h00, 1, 4);
    txn(2, 1'b1, 4'd5, 8'h3C, 1, 4);
    txn(3, 1'b0, 4'd13, 8'h00, 1, 2);

    for (int i = 0; i < N; i++) drive(i, 1'b0, 4'(i), 8'h00, 1);
    collect(1, 1, 1, 1);
    chk_order("contention", '{0, 1, 2, 3});

    drive(0, 1'b0, 4'd4, 8'h00, 1);
    drive(3, 1'b0, 4'd3, 8'h00, 1);
    for (int k = 0; k < 2; k++) begin
      sbq.push_back(predict(0, 1'b0, 4'd4, 8'h00, 1));
      sbq.push_back(predict(3, 1'b0, 4'd3, 8'h00, 1));
    end
    collect(3, 0, 0, 3);
    chk_order("fairness", '{0, 3, 0, 3, 0, 3});

    txn(0, 1'b1, 4'd7, 8'h55, 1, 3 + TMO);
    txn(1, 1'b0, 4'd9, 8'h00, TMO + 1, 3 + TMO);
    txn(2, 1'b0, 4'd6, 8'h00, TMO, 3 + TMO);

    drive(1, 1'b0, 4'd2, 8'h00, 3);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    for (int m = sbq.size() - 1; m >= 0; m--)
      if (sbq[m].id == 1) sbq.delete(m);
    req[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_no_rsp", rsp_valid, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 1'b0, 4'd0, 8'h00, 1);
    drive(3, 1'b0, 4'd3, 8'h00, 1);
    collect(1, 0, 0, 1);
    chk_order("after_reset", '{0, 3});

    issued = 0;
    for (int i = 0; i < N; i++) begin
      act[i] = 0; gap[i] = 0; age[i] = 0;
    end
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      v = rsp_valid;
      @(posedge clk); #1;
      any = 0;
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          age[i]++;
          if (v[i]) begin
            req[i] = 1'b0;
            act[i] = 0;
            gap[i] = $urandom_range(0, 3);
          end else if (age[i] > 60) begin
            chk("rand_watchdog", age[i], 0);
            req[i] = 1'b0;
            act[i] = 0;
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else if (issued < 240) begin
          r = $urandom_range(0, 7);
          drive(i, 1'($urandom_range(0, 1)),
                4'(i + 4 * $urandom_range(0, 3)), 8'($urandom),
                (r == 0) ? TMO + 1 : 1 + r % TMO);
          act[i] = 1;
          age[i] = 0;
          issued++;
        end
        if (act[i]) any = 1;
      end
      if (issued >= 240 && !any) break;
    end

    repeat (4) @(posedge clk);
    chk("sbq_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
